mem_port_arbiter: RTL and testbench

Shares the single-port synchronous data RAM between two requesters: the processor's fetch/execute path (CPU) and a debug/loader port (DBG). It grants at most one access per cycle, using round-robin on ties. A lock lets a requester hold ownership across a read-modify-write, and the lock is bounded by a timeout. The block sits between the processor/debug masters and the RAM array.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_rr_arb2.sv | 30 +++
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the data-RAM port arbiter.
//   owner_t : which requester currently holds a lock (none, CPU, DBG)
//   REQ_CPU / REQ_DBG : bit positions of each requester in two-bit request/grant vectors
//   LAST_CPU / LAST_DBG : encodings of the round-robin "last granted" pointer
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    localparam int REQ_CPU = 0;
    localparam int REQ_DBG = 1;

    localparam logic LAST_CPU = 1'b0;
    localparam logic LAST_DBG = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker.
//   req  [1:0] : raw request bits, indexed by REQ_CPU / REQ_DBG
//   last       : requester granted most recently (LAST_CPU / LAST_DBG)
//   mask [1:0] : 1 = requester is locked out this cycle
//   gnt  [1:0] : one-hot grant (or zero when nobody is eligible)
// On a tie the requester that was not granted last wins.
module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);

    logic [1:0] eligible_s;

    // Pick one eligible requester, alternating on ties.
    always_comb begin
        eligible_s = req & ~mask;
        gnt        = 2'b00;
        case (eligible_s)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == LAST_DBG) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port synchronous data RAM between the CPU path and the
// debug/loader port. At most one access is issued per cycle; ties alternate.
// A requester may lock the RAM across a read-modify-write; a lock is released
// when the owner drops lock or after MAX_LOCK cycles of holding.
// Ports:
//   clk, reset (async, active-low)
//   cpu_* / dbg_* : req, we, lock, addr, wdata in; gnt (combinational), rvalid out
//   rdata         : read data for whichever requester has rvalid, else 0
//   ram_*         : RAM strobe, write enable, address, write data out; ram_rdata in
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_lock,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic              dbg_lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              cpu_gnt,
    output logic              dbg_gnt,
    output logic              cpu_rvalid,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int                LCNT_W   = $clog2(MAX_LOCK + 1);
    localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(MAX_LOCK);

    owner_t            state_r;
    owner_t            state_nxt_s;
    logic              last_r;
    logic              last_nxt_s;
    logic              last_eff_s;
    logic [LCNT_W-1:0] lcnt_r;
    logic [LCNT_W-1:0] lcnt_nxt_s;
    logic              rv_cpu_r;
    logic              rv_dbg_r;
    logic              hold_s;
    logic [1:0]        mask_s;
    logic [1:0]        arb_gnt_s;
    logic [1:0]        gnt_s;

    // Decide whether a lock is still being held, and shape the arbiter inputs.
    // A releasing owner is treated as "last" so the other side wins a tie.
    always_comb begin
        hold_s     = 1'b0;
        mask_s     = 2'b00;
        last_eff_s = last_r;
        case (state_r)
            OWN_CPU: begin
                if (cpu_lock && (lcnt_r < LCNT_MAX)) begin
                    hold_s = 1'b1;
                    mask_s = 2'b10;
                end else begin
                    last_eff_s = LAST_CPU;
                end
            end
            OWN_DBG: begin
                if (dbg_lock && (lcnt_r < LCNT_MAX)) begin
                    hold_s = 1'b1;
                    mask_s = 2'b01;
                end else begin
                    last_eff_s = LAST_DBG;
                end
            end
            default: begin
                hold_s     = 1'b0;
                mask_s     = 2'b00;
                last_eff_s = last_r;
            end
        endcase
    end

    rr_arb2 u_rr_arb2 (
        .req  ({dbg_req, cpu_req}),
        .last (last_eff_s),
        .mask (mask_s),
        .gnt  (arb_gnt_s)
    );

    // Grants are suppressed while reset is asserted so every output reads 0.
    assign gnt_s   = reset ? arb_gnt_s : 2'b00;
    assign cpu_gnt = gnt_s[REQ_CPU];
    assign dbg_gnt = gnt_s[REQ_DBG];

    // Steer the winner's command onto the RAM port; idle port drives zeros.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = {ADDR_W{1'b0}};
        ram_wdata = {DATA_W{1'b0}};
        if (gnt_s[REQ_CPU]) begin
            ram_en    = 1'b1;
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else if (gnt_s[REQ_DBG]) begin
            ram_en    = 1'b1;
            ram_we    = dbg_we;
            ram_addr  = dbg_addr;
            ram_wdata = dbg_wdata;
        end else begin
            ram_en    = 1'b0;
            ram_we    = 1'b0;
            ram_addr  = {ADDR_W{1'b0}};
            ram_wdata = {DATA_W{1'b0}};
        end
    end

    // Owner FSM, lock counter and round-robin pointer next-state.
    // The counter advances every held cycle regardless of the owner's req.
    always_comb begin
        state_nxt_s = OWN_IDLE;
        lcnt_nxt_s  = {LCNT_W{1'b0}};
        last_nxt_s  = last_r;
        if (hold_s) begin
            state_nxt_s = state_r;
            lcnt_nxt_s  = lcnt_r + LCNT_W'(1);
        end else if (gnt_s[REQ_CPU] && cpu_lock) begin
            state_nxt_s = OWN_CPU;
            lcnt_nxt_s  = {LCNT_W{1'b0}};
        end else if (gnt_s[REQ_DBG] && dbg_lock) begin
            state_nxt_s = OWN_DBG;
            lcnt_nxt_s  = {LCNT_W{1'b0}};
        end else begin
            state_nxt_s = OWN_IDLE;
            lcnt_nxt_s  = {LCNT_W{1'b0}};
        end
        if (gnt_s[REQ_CPU]) begin
            last_nxt_s = LAST_CPU;
        end else if (gnt_s[REQ_DBG]) begin
            last_nxt_s = LAST_DBG;
        end else begin
            last_nxt_s = last_r;
        end
    end

    // State registers; reset discards any lock and pending read returns.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= OWN_IDLE;
            last_r   <= LAST_DBG;
            lcnt_r   <= {LCNT_W{1'b0}};
            rv_cpu_r <= 1'b0;
            rv_dbg_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            last_r   <= last_nxt_s;
            lcnt_r   <= lcnt_nxt_s;
            rv_cpu_r <= gnt_s[REQ_CPU] & ~cpu_we;
            rv_dbg_r <= gnt_s[REQ_DBG] & ~dbg_we;
        end
    end

    assign cpu_rvalid = rv_cpu_r;
    assign dbg_rvalid = rv_dbg_r;
    assign rdata      = (rv_cpu_r | rv_dbg_r) ? ram_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a write-first RAM model.
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;
    localparam int MAX_LOCK = 8;

    logic              clk;
    logic              reset;
    logic              cpu_req, cpu_we, cpu_lock;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              dbg_req, dbg_we, dbg_lock;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid;
    logic [DATA_W-1:0] rdata;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .cpu_gnt(cpu_gnt), .dbg_gnt(dbg_gnt),
        .cpu_rvalid(cpu_rvalid), .dbg_rvalid(dbg_rvalid), .rdata(rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM, write-first
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                ram_rdata     <= ram_wdata;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_lock = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_lock = 1'b0; dbg_addr = 16'h0000; dbg_wdata = 16'h0000;
    endtask

    task automatic cpu_cmd(input logic req, input logic we, input logic lock,
                           input logic [15:0] addr, input logic [15:0] wdata);
        cpu_req = req; cpu_we = we; cpu_lock = lock; cpu_addr = addr; cpu_wdata = wdata;
    endtask

    task automatic dbg_cmd(input logic req, input logic we, input logic lock,
                           input logic [15:0] addr, input logic [15:0] wdata);
        dbg_req = req; dbg_we = we; dbg_lock = lock; dbg_addr = addr; dbg_wdata = wdata;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        cpu_req = 1'b1;
        dbg_req = 1'b1;
        step();
        #2;
        checks++;
        if ({cpu_gnt, dbg_gnt, ram_en, ram_we, cpu_rvalid, dbg_rvalid} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {cpu_gnt, dbg_gnt, ram_en, ram_we, cpu_rvalid, dbg_rvalid});
        end
        checks++;
        if ({ram_addr, ram_wdata} !== 32'h0000_0000) begin
            errors++;
            $display("FAIL reset_ram_bus: got %h expected 00000000", {ram_addr, ram_wdata});
        end
        checks++;
        if (rdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 0000", rdata);
        end
        idle_inputs();
        step();
        reset = 1'b1;
    endtask

    task automatic preload();
        logic [15:0] addrs [3];
        logic [15:0] datas [3];
        addrs[0] = 16'h000A; datas[0] = 16'h1234;
        addrs[1] = 16'h000B; datas[1] = 16'h5678;
        addrs[2] = 16'h000D; datas[2] = 16'h0005;
        for (int i = 0; i < 3; i++) begin
            step();
            dbg_cmd(1'b1, 1'b1, 1'b0, addrs[i], datas[i]);
        end
        step();
        idle_inputs();
        pulse_reset();
    endtask

    task automatic test_post_reset_tie();
        step();
        cpu_cmd(1'b1, 1'b0, 1'b0, 16'h000A, 16'h0000);
        dbg_cmd(1'b1, 1'b0, 1'b0, 16'h000B, 16'h0000);
        #2;
        checks++;
        if ({cpu_gnt, dbg_gnt, ram_en, ram_we} !== 4'b1010) begin
            errors++;
            $display("FAIL tie_c0_gnt: got %b expected 1010", {cpu_gnt, dbg_gnt, ram_en, ram_we});
        end
        checks++;
        if (ram_addr !== 16'h000A) begin
            errors++;
            $display("FAIL tie_c0_addr: got %h expected 000a", ram_addr);
        end
        step();
        cpu_cmd(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #2;
        checks++;
        if ({cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid} !== 4'b0110) begin
            errors++;
            $display("FAIL tie_c1_flags: got %b expected 0110", {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid});
        end
        checks++;
        if (rdata !== 16'h1234) begin
            errors++;
            $display("FAIL tie_c1_rdata: got %h expected 1234", rdata);
        end
        step();
        idle_inputs();
        #2;
        checks++;
        if ({cpu_gnt, dbg_gnt, ram_en, cpu_rvalid, dbg_rvalid} !== 5'b00001) begin
            errors++;
            $display("FAIL tie_c2_flags: got %b expected 00001",
                     {cpu_gnt, dbg_gnt, ram_en, cpu_rvalid, dbg_rvalid});
        end
        checks++;
        if ({rdata, ram_addr} !== 32'h5678_0000) begin
            errors++;
            $display("FAIL tie_c2_data: got %h expected 56780000", {rdata, ram_addr});
        end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_gnt;
        step();
        cpu_cmd(1'b1, 1'b0, 1'b0, 16'h000A, 16'h0000);
        dbg_cmd(1'b1, 1'b0, 1'b0, 16'h000B, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            #2;
            exp_gnt = (i % 2 == 0) ? 2'b10 : 2'b01;
            checks++;
            if ({cpu_gnt, dbg_gnt} !== exp_gnt) begin
                errors++;
                $display("FAIL fair_%0d: got %b expected %b", i, {cpu_gnt, dbg_gnt}, exp_gnt);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_locked_rmw();
        step();
        cpu_cmd(1'b1, 1'b0, 1'b1, 16'h000D, 16'h0000);
        dbg_cmd(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0077);
        #2;
        checks++;
        if ({cpu_gnt, dbg_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL rmw_entry: got %b expected 10", {cpu_gnt, dbg_gnt});
        end
        step();
        cpu_cmd(1'b0, 1'b0, 1'b1, 16'h000D, 16'h0000);
        #2;
        checks++;
        if ({cpu_gnt, dbg_gnt, cpu_rvalid, rdata} !== {3'b001, 16'h0005}) begin
            errors++;
            $display("FAIL rmw_hold: got %b/%h expected 001/0005", {cpu_gnt, dbg_gnt, cpu_rvalid}, rdata);
        end
        step();
        cpu_cmd(1'b1, 1'b1, 1'b1, 16'h000D, 16'h0004);
        #2;
        checks++;
        if ({cpu_gnt, dbg_gnt, ram_we, ram_wdata} !== {3'b101, 16'h0004}) begin
            errors++;
            $display("FAIL rmw_write: got %b/%h expected 101/0004", {cpu_gnt, dbg_gnt, ram_we}, ram_wdata);
        end
        step();
        cpu_cmd(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #2;
        checks++;
        if ({cpu_gnt, dbg_gnt, ram_addr} !== {2'b01, 16'h0020}) begin
            errors++;
            $display("FAIL rmw_release: got %b/%h expected 01/0020", {cpu_gnt, dbg_gnt}, ram_addr);
        end
        step();
        idle_inputs();
        cpu_cmd(1'b1, 1'b0, 1'b0, 16'h000D, 16'h0000);
        #2;
        checks++;
        if ({cpu_gnt, dbg_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL rmw_readback_gnt: got %b expected 10", {cpu_gnt, dbg_gnt});
        end
        step();
        idle_inputs();
        #2;
        checks++;
        if ({cpu_rvalid, rdata} !== {1'b1, 16'h0004}) begin
            errors++;
            $display("FAIL rmw_readback_data: got %b/%h expected 1/0004", cpu_rvalid, rdata);
        end
    endtask

    task automatic test_lock_timeout();
        logic exp_gnt;
        step();
        dbg_cmd(1'b1, 1'b0, 1'b1, 16'h000A, 16'h0000);
        #2;
        checks++;
        if ({cpu_gnt, dbg_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL timeout_entry: got %b expected 01", {cpu_gnt, dbg_gnt});
        end
        for (int i = 1; i <= MAX_LOCK + 1; i++) begin
            step();
            dbg_cmd(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
            cpu_cmd(1'b1, 1'b0, 1'b0, 16'h000B, 16'h0000);
            #2;
            exp_gnt = (i == MAX_LOCK + 1);
            checks++;
            if (cpu_gnt !== exp_gnt) begin
                errors++;
                $display("FAIL timeout_cycle_%0d: got %b expected %b", i, cpu_gnt, exp_gnt);
            end
        end
        step();
        #2;
        checks++;
        if (cpu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL timeout_idle: got %b expected 1", cpu_gnt);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        step();
        cpu_cmd(1'b1, 1'b0, 1'b1, 16'h000A, 16'h0000);
        #2;
        checks++;
        if (cpu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL midrst_gnt: got %b expected 1", cpu_gnt);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({cpu_gnt, dbg_gnt, ram_en, cpu_rvalid} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_async: got %b expected 0000", {cpu_gnt, dbg_gnt, ram_en, cpu_rvalid});
        end
        step();
        #2;
        checks++;
        if ({cpu_gnt, dbg_gnt, ram_en, ram_we, cpu_rvalid, dbg_rvalid, rdata, ram_addr} !==
            {6'b000000, 16'h0000, 16'h0000}) begin
            errors++;
            $display("FAIL midrst_outputs: got %b/%h/%h expected 000000/0000/0000",
                     {cpu_gnt, dbg_gnt, ram_en, ram_we, cpu_rvalid, dbg_rvalid}, rdata, ram_addr);
        end
        idle_inputs();
        reset = 1'b1;
        step();
        #2;
        checks++;
        if ({cpu_rvalid, dbg_rvalid, rdata} !== {2'b00, 16'h0000}) begin
            errors++;
            $display("FAIL midrst_no_rvalid: got %b/%h expected 00/0000", {cpu_rvalid, dbg_rvalid}, rdata);
        end
        step();
        cpu_cmd(1'b1, 1'b0, 1'b0, 16'h000A, 16'h0000);
        dbg_cmd(1'b1, 1'b0, 1'b0, 16'h000B, 16'h0000);
        #2;
        checks++;
        if ({cpu_gnt, dbg_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL midrst_tie: got %b expected 10", {cpu_gnt, dbg_gnt});
        end
        step();
        idle_inputs();
    endtask

    task automatic test_streaming();
        logic [15:0] exp_d;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_d = 16'(16'h0064 + i);
            dbg_cmd(1'b1, 1'b1, 1'b0, 16'(16'h0040 + i), exp_d);
            #2;
            checks++;
            if ({dbg_gnt, ram_we, ram_wdata} !== {2'b11, exp_d}) begin
                errors++;
                $display("FAIL stream_wr_%0d: got %b/%h expected 11/%h", i, {dbg_gnt, ram_we}, ram_wdata, exp_d);
            end
        end
        for (int i = 0; i <= 8; i++) begin
            step();
            idle_inputs();
            if (i < 8) cpu_cmd(1'b1, 1'b0, 1'b0, 16'(16'h0040 + i), 16'h0000);
            #2;
            if (i > 0) begin
                exp_d = 16'(16'h0064 + i - 1);
                checks++;
                if ({cpu_rvalid, rdata} !== {1'b1, exp_d}) begin
                    errors++;
                    $display("FAIL stream_rd_%0d: got %b/%h expected 1/%h", i - 1, cpu_rvalid, rdata, exp_d);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        step();
        cpu_cmd(1'b1, 1'b1, 1'b0, 16'h0050, 16'hBEEF);
        #2;
        checks++;
        if ({cpu_gnt, dbg_gnt, ram_we} !== 3'b101) begin
            errors++;
            $display("FAIL b2b_write: got %b expected 101", {cpu_gnt, dbg_gnt, ram_we});
        end
        step();
        idle_inputs();
        dbg_cmd(1'b1, 1'b0, 1'b0, 16'h0050, 16'h0000);
        #2;
        checks++;
        if ({cpu_gnt, dbg_gnt, ram_we} !== 3'b010) begin
            errors++;
            $display("FAIL b2b_read: got %b expected 010", {cpu_gnt, dbg_gnt, ram_we});
        end
        step();
        idle_inputs();
        #2;
        checks++;
        if ({dbg_rvalid, cpu_rvalid, rdata} !== {2'b10, 16'hBEEF}) begin
            errors++;
            $display("FAIL b2b_data: got %b/%h expected 10/beef", {dbg_rvalid, cpu_rvalid}, rdata);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        preload();
        test_post_reset_tie();
        test_fairness();
        test_locked_rmw();
        test_lock_timeout();
        test_reset_mid_read();
        test_streaming();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
